// File: rtl/pump_if.sv
// Pump scheduler bus: level-controller requests and the fault pair in, pump drive and status out.
interface pump_if;
  logic       tick;
  logic       fill_req;
  logic       drain_req;
  logic       fault;
  logic       fault_ack;
  logic       fill_pump_a;
  logic       fill_pump_b;
  logic       drain_pump;
  logic [2:0] state;
  logic       conflict;

  modport master (
    output tick, fill_req, drain_req, fault, fault_ack,
    input  fill_pump_a, fill_pump_b, drain_pump, state, conflict
  );
  modport slave (
    input  tick, fill_req, drain_req, fault, fault_ack,
    output fill_pump_a, fill_pump_b, drain_pump, state, conflict
  );
endinterface

// File: rtl/pump_scheduler.sv
// Fill/drain pump sequencer with min run time, min dead time and a latched fault.
// Optional lead-pump rotation between fill pumps A and B: define PUMP_ROTATE_EN.
module pump_scheduler #(
  parameter int MIN_ON  = 4,
  parameter int MIN_OFF = 3,
  parameter int CNT_W   = 8
) (
  input  logic   clock,
  input  logic   rst_n,
  pump_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    DRAIN = 3'd2,
    DEAD  = 3'd3,
    FAULT = 3'd4
  } st_t;

  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(MIN_OFF);

  st_t            st, nxt;
  logic [CNT_W-1:0] tmr;
  logic           lead;

  always_comb begin
    nxt = st;
    if (bus.fault) nxt = FAULT;
    else begin
      case (st)
        IDLE:
          if (bus.fill_req && !bus.drain_req)      nxt = FILL;
          else if (bus.drain_req && !bus.fill_req) nxt = DRAIN;
        FILL:
          if ((!bus.fill_req || bus.drain_req) && tmr >= ON_LIM) nxt = DEAD;
        DRAIN:
          if ((!bus.drain_req || bus.fill_req) && tmr >= ON_LIM) nxt = DEAD;
        DEAD:
          if (tmr >= OFF_LIM) nxt = IDLE;
        FAULT:
          if (bus.fault_ack) nxt = DEAD;
        default: nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so pumps switch on the same edge as the state.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      st              <= IDLE;
      tmr             <= '0;
      lead            <= 1'b0;
      bus.fill_pump_a <= 1'b0;
      bus.fill_pump_b <= 1'b0;
      bus.drain_pump  <= 1'b0;
      bus.conflict    <= 1'b0;
    end else begin
      st <= nxt;
      if (nxt != st)                   tmr <= '0;
      else if (bus.tick && tmr != '1)  tmr <= tmr + 1'b1;
`ifdef PUMP_ROTATE_EN
      if (st == FILL && nxt == DEAD) lead <= ~lead;
      bus.fill_pump_a <= (nxt == FILL) && !lead;
      bus.fill_pump_b <= (nxt == FILL) &&  lead;
`else
      lead            <= 1'b0;
      bus.fill_pump_a <= (nxt == FILL);
      bus.fill_pump_b <= 1'b0;
`endif
      bus.drain_pump  <= (nxt == DRAIN);
      bus.conflict    <= (nxt == IDLE) && bus.fill_req && bus.drain_req;
    end
  end

  assign bus.state = st;
endmodule

// File: tb/tb_pump_scheduler.sv
// Bench for pump_scheduler: per-cycle comparison against a rule-level model plus directed scenarios.
module tb_pump_scheduler;
  localparam int MIN_ON  = 4;
  localparam int MIN_OFF = 3;
`ifdef PUMP_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  bit   slow  = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  always #5 clock = ~clock;

  pump_if bus();
  pump_scheduler #(.MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .CNT_W(8)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // tick generator: every cycle, or every 4th cycle in slow mode
  int tc = 0;
  always @(negedge clock) begin
    tc++;
    bus.tick = slow ? (tc % 4 == 0) : 1'b1;
  end

  // Rule-level model: mode number, run/off counter and lead pump
  int m_st = 0, m_tmr = 0;
  bit m_lead = 0, m_a = 0, m_b = 0, m_d = 0, m_c = 0, mv = 0;
  always @(posedge clock) begin
    int nx;
    bit f, d;
    f = bus.fill_req; d = bus.drain_req;
    mv = 1;
    if (!rst_n) begin
      m_st = 0; m_tmr = 0; m_lead = 0; m_c = 0;
    end else begin
      nx = m_st;
      if (bus.fault) nx = 4;
      else if (m_st == 0) nx = (f && !d) ? 1 : (d && !f) ? 2 : 0;
      else if (m_st == 1 && (!f || d) && m_tmr >= MIN_ON) nx = 3;
      else if (m_st == 2 && (!d || f) && m_tmr >= MIN_ON) nx = 3;
      else if (m_st == 3 && m_tmr >= MIN_OFF) nx = 0;
      else if (m_st == 4 && bus.fault_ack) nx = 3;
      if (ROT && m_st == 1 && nx == 3) m_lead = !m_lead;
      if (nx != m_st) m_tmr = 0;
      else if (bus.tick && m_tmr < 255) m_tmr++;
      m_c = (nx == 0) && f && d;
      m_st = nx;
    end
    m_a = (m_st == 1) && !m_lead;
    m_b = (m_st == 1) && m_lead;
    m_d = (m_st == 2);
  end

  always @(negedge clock) begin
    if (mv) begin
      chk("m_state", int'(bus.state), m_st);
      chk("m_fill_a", int'(bus.fill_pump_a), int'(m_a));
      chk("m_fill_b", int'(bus.fill_pump_b), int'(m_b));
      chk("m_drain", int'(bus.drain_pump), int'(m_d));
      chk("m_conflict", int'(bus.conflict), int'(m_c));
      chk("one_pump", int'(bus.fill_pump_a) + int'(bus.fill_pump_b) + int'(bus.drain_pump) <= 1, 1);
    end
  end

  // counts consecutive observed cycles in state st; a full bound means the state never left
  task automatic wait_state(int st, int mx, output int n);
    n = 0;
    while (int'(bus.state) == st && n < mx) begin
      n++;
      @(negedge clock);
    end
    if (n >= mx) chk("wait_timeout", n, -1);
  endtask

  initial begin
    int n;
    bit pa [3];
    bus.fill_req = 0; bus.drain_req = 0; bus.fault = 0; bus.fault_ack = 0;
    repeat (2) @(negedge clock);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_pumps", int'({bus.fill_pump_a, bus.fill_pump_b, bus.drain_pump, bus.conflict}), 0);
    rst_n = 1;
    @(negedge clock);

    // single-cycle fill request: 5 FILL, 4 DEAD, then IDLE
    bus.fill_req = 1; @(negedge clock); bus.fill_req = 0;
    chk("s1_fill_a", int'(bus.fill_pump_a), 1);
    wait_state(1, 30, n); chk("s1_fill_len", n, 5);
    wait_state(3, 30, n); chk("s1_dead_len", n, 4);
    chk("s1_idle", int'(bus.state), 0);
    chk("s1_idle_pumps", int'({bus.fill_pump_a, bus.fill_pump_b, bus.drain_pump}), 0);

    // fill held, drain raised at timer=1
    bus.fill_req = 1; @(negedge clock);
    chk("s2_fill_b", int'(bus.fill_pump_b), int'(ROT));
    @(negedge clock); bus.drain_req = 1;
    wait_state(1, 30, n); chk("s2_fill_rest", n, 4);
    bus.fill_req = 0;
    wait_state(3, 30, n); chk("s2_dead_len", n, 4);
    wait_state(0, 30, n); chk("s2_idle_len", n, 1);
    chk("s2_drain_on", int'(bus.drain_pump), 1);
    bus.drain_req = 0;
    wait_state(2, 30, n); chk("s2_drain_len", n, 5);
    wait_state(3, 30, n);

    // conflict in IDLE
    bus.fill_req = 1; bus.drain_req = 1; @(negedge clock);
    chk("s3_conflict", int'(bus.conflict), 1);
    chk("s3_state", int'(bus.state), 0);
    @(negedge clock);
    chk("s3_conflict_hold", int'(bus.conflict), 1);
    bus.fill_req = 0; bus.drain_req = 0; @(negedge clock);
    chk("s3_conflict_clr", int'(bus.conflict), 0);

    // fault during DRAIN, ack ignored while fault held
    bus.drain_req = 1; @(negedge clock); @(negedge clock);
    bus.fault = 1; @(negedge clock);
    chk("s4_fault_state", int'(bus.state), 4);
    chk("s4_drain_off", int'(bus.drain_pump), 0);
    bus.fault_ack = 1; @(negedge clock);
    chk("s4_ack_ignored", int'(bus.state), 4);
    bus.fault = 0; bus.drain_req = 0; @(negedge clock);
    chk("s4_to_dead", int'(bus.state), 3);
    bus.fault_ack = 0;
    wait_state(3, 30, n); chk("s4_dead_len", n, 4);
    chk("s4_idle", int'(bus.state), 0);

    // three fill cycles: lead rotation
    for (int i = 0; i < 3; i++) begin
      bus.fill_req = 1; @(negedge clock); bus.fill_req = 0;
      pa[i] = bus.fill_pump_b;
      chk("s5_any_fill", int'(bus.fill_pump_a | bus.fill_pump_b), 1);
      wait_state(1, 30, n);
      wait_state(3, 30, n);
    end
    chk("s5_pump0_b", int'(pa[0]), 0);
    chk("s5_pump1_b", int'(pa[1]), int'(ROT));
    chk("s5_pump2_b", int'(pa[2]), 0);

    // slow tick, then reset mid-FILL
    slow = 1;
    bus.fill_req = 1; @(negedge clock); bus.fill_req = 0;
    repeat (8) @(negedge clock);
    chk("s6_still_fill", int'(bus.state), 1);
    rst_n = 0; @(negedge clock);
    chk("s6_rst_state", int'(bus.state), 0);
    chk("s6_rst_pumps", int'({bus.fill_pump_a, bus.fill_pump_b, bus.drain_pump}), 0);
    rst_n = 1; slow = 0; @(negedge clock);
    bus.fill_req = 1; @(negedge clock); bus.fill_req = 0;
    chk("s6_lead_a", int'(bus.fill_pump_a), 1);
    wait_state(1, 30, n);
    wait_state(3, 30, n);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
